instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, byte address fetched first after reset (word-aligned).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 rom_addr  output  8  word address to the instruction ROM = pc[9:2]; ROM returns data combinationally in the same cycle.
REQ-005 rom_instr  input  32  instruction word from the ROM for rom_addr.
REQ-006 redirect_valid  input  1  branch/jump redirect request, one-cycle pulse.
REQ-007 redirect_pc  input  32  redirect target byte address.
REQ-008 out_valid  output  1  out_instr/out_pc hold a valid fetched instruction.
REQ-009 out_ready  input  1  downstream decode accepts the instruction this cycle.
REQ-010 out_instr  output  32  fetched instruction.
REQ-011 out_pc  output  32  byte address of out_instr.
REQ-012 fault  output  1  sticky misaligned-redirect fault (only when FETCH_FAULT_EN is defined).

Function
REQ-013 The block SHALL contain a 32-bit pc register and a one-entry output register (out_valid, out_instr, out_pc).
REQ-014 FSM states SHALL be START, FETCH, FAULT; reset enters START; START -> FETCH unconditionally after one cycle; FETCH -> FAULT on a faulting redirect (REQ-022); FAULT exits only by reset.
REQ-015 In START, no instruction SHALL be captured and pc SHALL hold.
REQ-016 Advance condition in FETCH: no redirect_valid AND (out_valid == 0 OR out_ready == 1).
REQ-017 On advance: out_instr <= rom_instr, out_pc <= pc, out_valid <= 1, pc <= pc + 4.
REQ-018 In FETCH with out_valid == 1, out_ready == 0, no redirect: pc, out_instr, out_pc, out_valid SHALL hold unchanged (stall).
REQ-019 Handshake: the instruction SHALL transfer on a cycle with out_valid && out_ready; with no new fetch in that cycle (e.g., redirect), out_valid SHALL drop to 0 next cycle.
REQ-020 redirect_valid SHALL take priority over advance and stall: pc <= {redirect_pc[31:2], 2'b00}, out_valid <= 0 (flush); the flushed instruction SHALL never be presented.
REQ-021 Redirect latency: redirect in cycle N -> rom_addr = redirect_pc[9:2] in N+1 -> out_valid = 1 with out_pc = redirect_pc in N+2 (if not stalled).
REQ-022 A redirect with redirect_pc[1:0] != 0 is misaligned; its handling is set by REQ-028/REQ-029.
REQ-023 pc SHALL wrap modulo 2^32; rom_addr SHALL wrap from 8'hFF to 8'h00 as pc crosses each 1 KiB boundary, with no special action.
REQ-024 redirect_valid in START or FAULT SHALL be ignored.
REQ-025 In FAULT: out_valid = 0, pc holds, rom_addr holds.

Reset
REQ-026 On rst_n low, asynchronously: state = START, pc = RESET_PC, out_valid = 0, out_instr = 0, out_pc = 0, fault = 0; rom_addr = RESET_PC[9:2].
REQ-027 Reset asserted mid-stall or mid-redirect SHALL discard all in-flight state; first out_valid after release SHALL carry out_pc = RESET_PC in the second cycle after release.

Configuration
REQ-028 With FETCH_FAULT_EN defined: a misaligned redirect in FETCH SHALL flush, set fault = 1 next cycle, and enter FAULT.
REQ-029 Without FETCH_FAULT_EN: fault port SHALL be absent, FAULT state SHALL be unreachable, and misaligned redirects SHALL be treated as {redirect_pc[31:2], 2'b00} per REQ-020.

Verification
REQ-030 Reset release, out_ready = 1, ROM word k = 32'h1000_0000 + k -> out_valid rises second cycle after release; out_pc = 0, 4, 8 ... with out_instr = 32'h1000_0000, 32'h1000_0001, 32'h1000_0002 on consecutive cycles.
REQ-031 out_ready held 0 for 3 cycles while out_valid = 1 at out_pc = 8 -> out_pc/out_instr stable; rom_addr stays 3; after release, out_pc = 8, then 12 with no gap or duplicate.
REQ-032 redirect_valid with redirect_pc = 32'h40 while out_valid = 1 and out_ready = 0 -> out_valid = 0 next cycle; rom_addr = 8'h10; then out_pc = 32'h40.
REQ-033 Redirect to 32'h3FC, out_ready = 1 -> out_pc 32'h3FC (rom_addr 8'hFF), then 32'h400 (rom_addr 8'h00).
REQ-034 Redirect to 32'h42 -> with FETCH_FAULT_EN: fault = 1, out_valid stays 0 until rst_n; without: out_pc = 32'h40.
REQ-035 rst_n pulsed low during a stall at out_pc = 32'h20 -> outputs clear immediately; fetch resumes at RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: pc register, ROM word addressing, one-entry output register with valid/ready.
// Optional misaligned-redirect fault handling is enabled by defining FETCH_FAULT_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  rom_addr,
  input  logic [31:0] rom_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef FETCH_FAULT_EN
  ,
  output logic        fault
`endif
);

  localparam int unsigned XLEN     = 32;
  localparam int unsigned PC_STEP  = 4;
`ifdef FETCH_FAULT_EN
  localparam bit          FAULT_EN = 1'b1;
`else
  localparam bit          FAULT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_FETCH = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_pc;
  logic              r_out_valid;
  logic [XLEN-1:0]   r_out_instr;
  logic [XLEN-1:0]   r_out_pc;
`ifdef FETCH_FAULT_EN
  logic              r_fault;
`endif

  logic              w_advance;
  logic              w_misaligned;
  logic              w_fault_redirect;
  logic [XLEN-1:0]   w_redirect_target;

  // A slot opens when the output register is empty or being drained this cycle.
  assign w_advance         = !redirect_valid && (!r_out_valid || out_ready);
  assign w_misaligned      = |redirect_pc[1:0];
  assign w_fault_redirect  = FAULT_EN && w_misaligned;
  assign w_redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_START;
      r_pc        <= RESET_PC;
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_pc    <= '0;
`ifdef FETCH_FAULT_EN
      r_fault     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_START: begin
          r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          // Redirect beats both advance and stall; the held instruction is flushed.
          if (redirect_valid) begin
            r_out_valid <= 1'b0;
            if (w_fault_redirect) begin
              r_state <= ST_FAULT;
`ifdef FETCH_FAULT_EN
              r_fault <= 1'b1;
`endif
            end else begin
              r_pc <= w_redirect_target;
            end
          end else if (w_advance) begin
            r_out_instr <= rom_instr;
            r_out_pc    <= r_pc;
            r_out_valid <= 1'b1;
            r_pc        <= r_pc + XLEN'(PC_STEP);
          end
        end
        ST_FAULT: begin
          r_out_valid <= 1'b0;
        end
        default: begin
          r_state <= ST_START;
        end
      endcase
    end
  end

  assign rom_addr  = r_pc[9:2];
  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_pc    = r_out_pc;
`ifdef FETCH_FAULT_EN
  assign fault     = r_fault;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table for the main flow plus hand sequences for reset corners.
// Builds with or without FETCH_FAULT_EN.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rom_addr;
  logic [31:0] rom_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef FETCH_FAULT_EN
  logic        fault;
`endif

  int n_checks;
  int n_errors;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_instr      (rom_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
`ifdef FETCH_FAULT_EN
    ,
    .fault          (fault)
`endif
  );

  // ROM word k holds 0x1000_0000 + k
  always_comb rom_instr = 32'h1000_0000 + {24'h0, rom_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        redir;
    logic [31:0] redir_pc;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [7:0]  exp_rom;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic rd, input logic [31:0] rpc, input logic rdy,
                         input logic ev, input logic [31:0] epc, input logic [7:0] erom);
    vecs[i].redir     = rd;
    vecs[i].redir_pc  = rpc;
    vecs[i].ready     = rdy;
    vecs[i].exp_valid = ev;
    vecs[i].exp_pc    = epc;
    vecs[i].exp_instr = 32'h1000_0000 + {24'h0, epc[9:2]};
    vecs[i].exp_rom   = erom;
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;

    //       idx redir pc            rdy valid out_pc       rom
    set_vec(0,  0, 32'h0,         1, 0, 32'h0,         8'h00); // START cycle
    set_vec(1,  0, 32'h0,         1, 1, 32'h0,         8'h01);
    set_vec(2,  0, 32'h0,         1, 1, 32'h4,         8'h02);
    set_vec(3,  0, 32'h0,         1, 1, 32'h8,         8'h03);
    set_vec(4,  0, 32'h0,         0, 1, 32'h8,         8'h03); // stall x3
    set_vec(5,  0, 32'h0,         0, 1, 32'h8,         8'h03);
    set_vec(6,  0, 32'h0,         0, 1, 32'h8,         8'h03);
    set_vec(7,  0, 32'h0,         1, 1, 32'hC,         8'h04);
    set_vec(8,  1, 32'h40,        0, 0, 32'h0,         8'h10); // redirect during stall
    set_vec(9,  0, 32'h0,         0, 1, 32'h40,        8'h11);
    set_vec(10, 1, 32'h3FC,       1, 0, 32'h0,         8'hFF); // redirect on transfer
    set_vec(11, 0, 32'h0,         1, 1, 32'h3FC,       8'h00);
    set_vec(12, 0, 32'h0,         1, 1, 32'h400,       8'h01);
`ifdef FETCH_FAULT_EN
    set_vec(13, 1, 32'h42,        1, 0, 32'h0,         8'h01); // misaligned -> FAULT
    set_vec(14, 0, 32'h0,         1, 0, 32'h0,         8'h01);
    set_vec(15, 1, 32'h80,        1, 0, 32'h0,         8'h01); // ignored in FAULT
    set_vec(16, 0, 32'h0,         1, 0, 32'h0,         8'h01);
`else
    set_vec(13, 1, 32'h42,        1, 0, 32'h0,         8'h10); // misaligned -> aligned down
    set_vec(14, 0, 32'h0,         1, 1, 32'h40,        8'h11);
    set_vec(15, 1, 32'h80,        1, 0, 32'h0,         8'h20);
    set_vec(16, 0, 32'h0,         1, 1, 32'h80,        8'h21);
`endif

    // Reset state
    #12;
    check("rst_valid", 0, 32'(out_valid), 32'h0);
    check("rst_pc",    0, out_pc,         32'h0);
    check("rst_instr", 0, out_instr,      32'h0);
    check("rst_rom",   0, 32'(rom_addr),  32'h0);
`ifdef FETCH_FAULT_EN
    check("rst_fault", 0, 32'(fault),     32'h0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].redir_pc;
      out_ready      = vecs[i].ready;
      step();
      redirect_valid = 1'b0;
      check("valid", i, 32'(out_valid), 32'(vecs[i].exp_valid));
      check("rom_addr", i, 32'(rom_addr), 32'(vecs[i].exp_rom));
      if (vecs[i].exp_valid) begin
        check("out_pc", i, out_pc, vecs[i].exp_pc);
        check("out_instr", i, out_instr, vecs[i].exp_instr);
      end
    end
`ifdef FETCH_FAULT_EN
    check("fault_sticky", 0, 32'(fault), 32'h1);
`endif

    // Reset during a stall at 0x20 clears outputs at once
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    begin
      int budget;
      budget = 0;
      while (!(out_valid && out_pc == 32'h20) && budget < 40) begin
        step();
        budget++;
      end
      check("reach_0x20", 0, 32'(budget < 40), 32'h1);
    end
    out_ready = 1'b0;
    step();
    step();
    check("stall_pc",  1, out_pc,         32'h20);
    check("stall_rom", 1, 32'(rom_addr),  32'h09);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", 1, 32'(out_valid), 32'h0);
    check("async_pc",    1, out_pc,          32'h0);
    check("async_instr", 1, out_instr,       32'h0);
    check("async_rom",   1, 32'(rom_addr),   32'h0);
`ifdef FETCH_FAULT_EN
    check("async_fault", 1, 32'(fault),      32'h0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Redirect in START is ignored; first valid carries RESET_PC
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    out_ready      = 1'b1;
    step();
    redirect_valid = 1'b0;
    check("start_valid", 2, 32'(out_valid), 32'h0);
    check("start_rom",   2, 32'(rom_addr),  32'h0);
    step();
    check("resume_valid", 2, 32'(out_valid), 32'h1);
    check("resume_pc",    2, out_pc,         32'h0);
    check("resume_instr", 2, out_instr,      32'h1000_0000);
    step();
    check("resume_pc2",   2, out_pc,         32'h4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
